pipe_reg_chain: RTL and testbench

- Parametrised successor to the single-stage enabled pipeline register used between MIPS datapath stages.
- Provides a DEPTH-deep chain of WIDTH-bit registers, each carrying a valid bit. All stages share one enable (stall) and one flush that inserts bubbles.
- Keeps a registered count of in-flight valid entries for hazard and forwarding logic.
- Sits between pipeline stages (e.g. IF/ID, ID/EX, EX/MEM) and as a generic multi-cycle delay line.

---
 rtl/pipe_reg_chain.sv | 89 ++++++++
 tb/tb_pipe_reg_chain.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_reg_chain.sv
// DEPTH-deep chain of enabled pipeline registers with per-stage valid bits,
// a common stall/flush, and a registered count of in-flight valid entries.
module pipe_reg_chain #(
   parameter int               WIDTH        = 32,
   parameter int               DEPTH        = 1,
   parameter logic [WIDTH-1:0] FLUSH_VALUE  = '0,
   parameter bit               GATE_INVALID = 1'b0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [WIDTH-1:0]           dataIn,
   input  logic                       validIn,
   input  logic                       control,
   input  logic                       flush,
   output logic [WIDTH-1:0]           dataOut,
   output logic                       validOut,
   output logic [$clog2(DEPTH+1)-1:0] occupancy
);
   localparam int OCC_W = $clog2(DEPTH + 1);

   generate
      if (DEPTH < 1 || DEPTH > 16) begin : g_bad_depth
         $error("pipe_reg_chain: DEPTH must be in the range 1..16");
      end
   endgenerate

   // Gated bubbles store FLUSH_VALUE so an undriven dataIn never enters the chain.
   function automatic logic [WIDTH-1:0] capture_data(input logic             vin,
                                                     input logic [WIDTH-1:0] din);
      if (GATE_INVALID && !vin) begin
         return FLUSH_VALUE;
      end
      return din;
   endfunction

   // Subtract the departing entry first: occ >= vout always holds, so no wrap.
   function automatic logic [OCC_W-1:0] next_occ(input logic [OCC_W-1:0] occ,
                                                 input logic             vin,
                                                 input logic             vout);
      return occ - OCC_W'(vout) + OCC_W'(vin);
   endfunction

   logic [WIDTH-1:0] data_q  [DEPTH];
   logic [WIDTH-1:0] data_d  [DEPTH];
   logic [DEPTH-1:0] valid_q;
   logic [DEPTH-1:0] valid_d;
   logic [OCC_W-1:0] occ_q;
   logic [OCC_W-1:0] occ_d;

   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      occ_d   = occ_q;
      if (flush) begin
         for (int k = 0; k < DEPTH; k++) begin
            data_d[k] = FLUSH_VALUE;
         end
         valid_d = '0;
         occ_d   = '0;
      end else if (control) begin
         data_d[0]  = capture_data(validIn, dataIn);
         valid_d[0] = validIn;
         for (int k = 1; k < DEPTH; k++) begin
            data_d[k]  = data_q[k-1];
            valid_d[k] = valid_q[k-1];
         end
         occ_d = next_occ(occ_q, validIn, valid_q[DEPTH-1]);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < DEPTH; k++) begin
            data_q[k] <= FLUSH_VALUE;
         end
         valid_q <= '0;
         occ_q   <= '0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
         occ_q   <= occ_d;
      end
   end

   assign dataOut   = data_q[DEPTH-1];
   assign validOut  = valid_q[DEPTH-1];
   assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Bench for pipe_reg_chain: five configurations share one stimulus stream; a
// queue-based reference per configuration predicts every output each cycle.
module tb_pipe_reg_chain;
   typedef logic [32:0] ent_t;

   localparam int          NM      = 5;
   localparam int          DEP [NM] = '{3, 2, 4, 2, 1};
   localparam logic [31:0] FV  [NM] = '{32'h0, 32'h0, 32'hF1F1F1F1, 32'h00000BAD, 32'h0};
   localparam bit          GT  [NM] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

   logic        clk = 1'b0;
   logic        reset, flush, control, validIn;
   logic [31:0] dataIn;
   logic [31:0] dout [NM];
   logic        vout [NM];
   logic [1:0]  occ0, occ1, occ3;
   logic [2:0]  occ2;
   logic [0:0]  occ4;
   int          occ_i [NM];

   int checks   = 0;
   int failures = 0;

   ent_t mq [NM][$];

   always #5 clk = ~clk;

   pipe_reg_chain #(.WIDTH(32), .DEPTH(3), .FLUSH_VALUE(32'h0), .GATE_INVALID(1'b0)) u_d0 (
      .clk(clk), .reset(reset), .dataIn(dataIn), .validIn(validIn), .control(control),
      .flush(flush), .dataOut(dout[0]), .validOut(vout[0]), .occupancy(occ0));
   pipe_reg_chain #(.WIDTH(32), .DEPTH(2), .FLUSH_VALUE(32'h0), .GATE_INVALID(1'b0)) u_d1 (
      .clk(clk), .reset(reset), .dataIn(dataIn), .validIn(validIn), .control(control),
      .flush(flush), .dataOut(dout[1]), .validOut(vout[1]), .occupancy(occ1));
   pipe_reg_chain #(.WIDTH(32), .DEPTH(4), .FLUSH_VALUE(32'hF1F1F1F1), .GATE_INVALID(1'b0)) u_d2 (
      .clk(clk), .reset(reset), .dataIn(dataIn), .validIn(validIn), .control(control),
      .flush(flush), .dataOut(dout[2]), .validOut(vout[2]), .occupancy(occ2));
   pipe_reg_chain #(.WIDTH(32), .DEPTH(2), .FLUSH_VALUE(32'h00000BAD), .GATE_INVALID(1'b1)) u_d3 (
      .clk(clk), .reset(reset), .dataIn(dataIn), .validIn(validIn), .control(control),
      .flush(flush), .dataOut(dout[3]), .validOut(vout[3]), .occupancy(occ3));
   pipe_reg_chain #(.WIDTH(32), .DEPTH(1), .FLUSH_VALUE(32'h0), .GATE_INVALID(1'b0)) u_d4 (
      .clk(clk), .reset(reset), .dataIn(dataIn), .validIn(validIn), .control(control),
      .flush(flush), .dataOut(dout[4]), .validOut(vout[4]), .occupancy(occ4));

   assign occ_i[0] = int'(occ0);
   assign occ_i[1] = int'(occ1);
   assign occ_i[2] = int'(occ2);
   assign occ_i[3] = int'(occ3);
   assign occ_i[4] = int'(occ4);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: mq[m][0] is the last stage; an enabled edge drops it and appends the new entry.
   task automatic model_edge(input logic r, input logic f, input logic e,
                             input logic vi, input logic [31:0] di);
      for (int m = 0; m < NM; m++) begin
         if (r || f) begin
            mq[m].delete();
            for (int k = 0; k < DEP[m]; k++) mq[m].push_back({1'b0, FV[m]});
         end else if (e) begin
            void'(mq[m].pop_front());
            mq[m].push_back({vi, (GT[m] && !vi) ? FV[m] : di});
         end
      end
   endtask

   task automatic check_all();
      for (int m = 0; m < NM; m++) begin
         ent_t e;
         int   cnt;
         e   = mq[m][0];
         cnt = 0;
         foreach (mq[m][i]) cnt += int'(mq[m][i][32]);
         chk($sformatf("d%0d_data", m), dout[m], e[31:0]);
         chk($sformatf("d%0d_valid", m), 32'(vout[m]), 32'(e[32]));
         chk($sformatf("d%0d_occ", m), occ_i[m], cnt);
      end
   endtask

   task automatic step(input logic r, input logic f, input logic e,
                       input logic vi, input logic [31:0] di);
      reset   = r;
      flush   = f;
      control = e;
      validIn = vi;
      dataIn  = di;
      @(posedge clk);
      model_edge(r, f, e, vi, di);
      #1;
      check_all();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; flush = 1'b0; control = 1'b0; validIn = 1'b0; dataIn = '0;

      // Reset held with valid traffic present
      for (int i = 0; i < 2; i++) begin
         step(1, 0, 1, 1, 32'hDEADBEEF);
         chk("rst_data", dout[0], 32'h0);
         chk("rst_valid", 32'(vout[0]), 32'h0);
         chk("rst_occ", occ_i[0], 0);
      end
      step(0, 0, 0, 1, 32'hDEADBEEF);
      chk("rst_rel_data", dout[0], 32'h0);
      chk("rst_rel_valid", 32'(vout[0]), 32'h0);
      chk("rst_rel_occ", occ_i[0], 0);

      // Stream through DEPTH=3
      step(1, 0, 0, 0, 0);
      step(0, 0, 1, 1, 32'h11); chk("str_occ1", occ_i[0], 1);
      step(0, 0, 1, 1, 32'h22); chk("str_occ2", occ_i[0], 2);
      step(0, 0, 1, 1, 32'h33); chk("str_occ3", occ_i[0], 3);
      chk("str_out11", dout[0], 32'h11); chk("str_v11", 32'(vout[0]), 32'h1);
      step(0, 0, 1, 1, 32'h44); chk("str_occ4", occ_i[0], 3);
      chk("str_out22", dout[0], 32'h22);
      step(0, 0, 1, 0, 32'h0); chk("str_out33", dout[0], 32'h33);
      step(0, 0, 1, 0, 32'h0); chk("str_out44", dout[0], 32'h44);
      chk("str_v44", 32'(vout[0]), 32'h1);

      // Stall on DEPTH=2
      step(1, 0, 0, 0, 0);
      step(0, 0, 1, 1, 32'hA);
      step(0, 0, 1, 1, 32'hB);
      chk("stl_loaded", dout[1], 32'hA); chk("stl_occ_loaded", occ_i[1], 2);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 1, 32'hC);
         chk("stl_hold_data", dout[1], 32'hA);
         chk("stl_hold_occ", occ_i[1], 2);
      end
      step(0, 0, 1, 1, 32'hC); chk("stl_resume_b", dout[1], 32'hB);
      step(0, 0, 1, 0, 32'h0); chk("stl_resume_c", dout[1], 32'hC);
      chk("stl_resume_cv", 32'(vout[1]), 32'h1);

      // Flush wins over a stall and discards the presented input (DEPTH=4)
      step(1, 0, 0, 0, 0);
      for (int i = 1; i <= 4; i++) step(0, 0, 1, 1, 32'(i));
      chk("fl_full_occ", occ_i[2], 4); chk("fl_full_out", dout[2], 32'h1);
      step(0, 1, 0, 1, 32'h55);
      chk("fl_data", dout[2], 32'hF1F1F1F1);
      chk("fl_valid", 32'(vout[2]), 32'h0);
      chk("fl_occ", occ_i[2], 0);
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 1, 0, 32'h0);
         chk("fl_no55_valid", 32'(vout[2]), 32'h0);
      end

      // Gated bubble on DEPTH=2 with GATE_INVALID=1
      step(1, 0, 0, 0, 0);
      step(0, 0, 1, 1, 32'h1);
      step(0, 0, 1, 0, 32'hFFFF);
      chk("gt_out1", dout[3], 32'h1); chk("gt_v1", 32'(vout[3]), 32'h1);
      step(0, 0, 1, 1, 32'h3);
      chk("gt_bubble", dout[3], 32'h00000BAD); chk("gt_vb", 32'(vout[3]), 32'h0);
      chk("gt_occ_b", occ_i[3], 1);
      step(0, 0, 1, 0, 32'h0);
      chk("gt_out3", dout[3], 32'h3); chk("gt_v3", 32'(vout[3]), 32'h1);
      step(0, 0, 1, 0, 32'h1234);
      chk("gt_gated_data", dout[3], 32'h00000BAD);

      // Reset together with flush while entries are in flight (DEPTH=4)
      step(1, 0, 0, 0, 0);
      step(0, 0, 1, 1, 32'h7);
      step(0, 0, 1, 1, 32'h8);
      step(0, 0, 1, 1, 32'h9);
      chk("rm_occ3", occ_i[2], 3);
      step(1, 1, 1, 1, 32'hAA);
      chk("rm_occ0", occ_i[2], 0); chk("rm_valid", 32'(vout[2]), 32'h0);
      chk("rm_data", dout[2], 32'hF1F1F1F1);
      step(0, 0, 1, 1, 32'hBB);
      for (int i = 0; i < 2; i++) begin
         step(0, 0, 1, 0, 32'h0);
         chk("rm_not_yet", 32'(vout[2]), 32'h0);
      end
      step(0, 0, 1, 0, 32'h0);
      chk("rm_emerge_data", dout[2], 32'hBB);
      chk("rm_emerge_valid", 32'(vout[2]), 32'h1);

      // Mixed random traffic for all configurations against the reference
      for (int i = 0; i < 40; i++) begin
         step(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 14) == 0),
              1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), $urandom);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
